pn_generator: RTL and testbench

- Bit-level PN test-pattern source. Consumes the static configuration from the PN generator register block and produces a PCM-encoded serial stream with its bit clock.
- Output feeds the PCM output mux / test-data path.
- Sections: 32-bit NCO bit-rate generator, configurable 2–24 stage LFSR (Fibonacci or Galois), PCM line encoder with optional inversion.

---
 rtl/pngen_pkg.sv | 34 +++
 rtl/pcm_encoder.sv | 60 ++++++
 rtl/pn_generator.sv | 153 +++++++++++++++
 tb/tb_pn_generator.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pngen_pkg.sv
// pngen_pkg -- shared definitions for the PN test-pattern generator.
//   PCM_*          : line-code select values for pcmMode (7..15 fall back to NRZ-L)
//   PN_WIDTH       : maximum LFSR stage count
//   RATE_WIDTH     : NCO accumulator / increment width
//   PN_LEN_MIN/MAX : clamp limits applied to pnPolyLength
//   clamp_len()    : clamps a requested stage count into [PN_LEN_MIN, PN_LEN_MAX]
package pngen_pkg;

  localparam int PN_WIDTH   = 24;
  localparam int RATE_WIDTH = 32;

  localparam int PN_LEN_MIN = 2;
  localparam int PN_LEN_MAX = 24;

  localparam logic [3:0] PCM_NRZL  = 4'd0;
  localparam logic [3:0] PCM_NRZM  = 4'd1;
  localparam logic [3:0] PCM_NRZS  = 4'd2;
  localparam logic [3:0] PCM_BIPHL = 4'd3;
  localparam logic [3:0] PCM_BIPHM = 4'd4;
  localparam logic [3:0] PCM_BIPHS = 4'd5;
  localparam logic [3:0] PCM_RZ    = 4'd6;

  typedef enum logic {
    PN_FIBONACCI = 1'b0,
    PN_GALOIS    = 1'b1
  } pn_mode_e;

  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    if (len < 5'(PN_LEN_MIN)) return 5'(PN_LEN_MIN);
    if (len > 5'(PN_LEN_MAX)) return 5'(PN_LEN_MAX);
    return len;
  endfunction

endpackage

// File: rtl/pcm_encoder.sv
// pcm_encoder -- PCM line encoder for the PN generator.
// Holds one registered line level that is updated at bit boundaries (bitEn)
// and, for the biphase and RZ codes, at the mid-bit point (midEn).
// Ports:
//   clk       : system clock
//   reset     : synchronous active-high reset (level -> 0)
//   dataBit   : bit being encoded (new bit on bitEn, current bit on midEn)
//   bitEn     : bit-boundary event
//   midEn     : mid-bit event (never coincident with bitEn)
//   pcmMode   : line-code select, see pngen_pkg PCM_*
//   pcmInvert : inverts the output (applied after the level register)
//   restart   : sequence restart pulse (level -> 0, overrides events)
//   data      : encoded serial data
module pcm_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       dataBit,
  input  logic       bitEn,
  input  logic       midEn,
  input  logic [3:0] pcmMode,
  input  logic       pcmInvert,
  input  logic       restart,
  output logic       data
);
  import pngen_pkg::*;

  logic level;
  logic level_next;

  always_comb begin
    // NOTE: default first so every path assigns level_next -- no latch.
    level_next = level;
    if (bitEn) begin
      unique case (pcmMode)
        PCM_NRZM:             if (dataBit)  level_next = ~level;
        PCM_NRZS:             if (!dataBit) level_next = ~level;
        PCM_BIPHM, PCM_BIPHS: level_next = ~level;
        // NRZ-L, Biphase-L, RZ and the unused codes all start the bit at b.
        default:              level_next = dataBit;
      endcase
    end else if (midEn) begin
      unique case (pcmMode)
        PCM_BIPHL: level_next = ~dataBit;
        PCM_BIPHM: if (dataBit)  level_next = ~level;
        PCM_BIPHS: if (!dataBit) level_next = ~level;
        PCM_RZ:    level_next = 1'b0;
        default:   level_next = level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart) level <= 1'b0;
    else                  level <= level_next;
  end

  // Inversion sits after the register so a pcmInvert change shows up at once.
  assign data = level ^ pcmInvert;

endmodule

// File: rtl/pn_generator.sv
// pn_generator -- bit-level PN test-pattern source.
// A 32-bit NCO sets the bit rate; each NCO overflow steps a 2..24 stage LFSR
// (Fibonacci or Galois) and the resulting bit is line-encoded by pcm_encoder.
// Optional build macro: PNGEN_EPOCH_EN enables the pnEpoch sequence-start
// pulse; without it pnEpoch is tied low.
// Ports:
//   clk          : system clock, all inputs synchronous
//   reset        : synchronous active-high reset
//   pnPolyTaps   : tap mask, bit k = stage k+1
//   pnPolyLength : stage count L, clamped to 2..24
//   pnPolyMode   : 0 = Fibonacci, 1 = Galois
//   pnClockRate  : NCO increment, bit rate = Fclk*rate/2^32 (rate < 2^31)
//   pcmMode      : line-code select
//   pcmInvert    : invert encoded output
//   pnRestart    : rising edge restarts the sequence
//   pnBit        : raw LFSR output bit
//   pnData       : encoded serial data
//   pnClk        : bit clock, low first half-bit, high second half
//   pnBitEn      : one-cycle pulse per bit boundary
//   pnEpoch      : one-cycle pulse when the register is (re)loaded with the seed
module pn_generator #(
  parameter int PN_WIDTH   = pngen_pkg::PN_WIDTH,
  parameter int RATE_WIDTH = pngen_pkg::RATE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PN_WIDTH-1:0]   pnPolyTaps,
  input  logic [4:0]            pnPolyLength,
  input  logic                  pnPolyMode,
  input  logic [RATE_WIDTH-1:0] pnClockRate,
  input  logic [3:0]            pcmMode,
  input  logic                  pcmInvert,
  input  logic                  pnRestart,
  output logic                  pnBit,
  output logic                  pnData,
  output logic                  pnClk,
  output logic                  pnBitEn,
  output logic                  pnEpoch
);
  import pngen_pkg::*;

  logic [RATE_WIDTH-1:0] acc;
  logic [RATE_WIDTH:0]   nco_sum;
  logic                  ovf;
  logic                  mid;

  logic [PN_WIDTH-1:0]   sr;
  logic [PN_WIDTH-1:0]   seed;
  logic [PN_WIDTH-1:0]   sr_step;
  logic [PN_WIDTH-1:0]   sr_next;
  logic [4:0]            len;
  logic                  step_out;
  logic                  fib_fb;

  logic                  restart_q;
  logic                  restart_edge;
  logic                  step_en;
  logic                  mid_en;
  logic                  enc_bit;

  // NCO: carry out of the accumulator marks a bit boundary, crossing the
  // half-scale point without a carry marks the mid-bit.
  assign nco_sum = {1'b0, acc} + {1'b0, pnClockRate};
  assign ovf     = nco_sum[RATE_WIDTH];
  assign mid     = nco_sum[RATE_WIDTH-1] & ~acc[RATE_WIDTH-1] & ~ovf;

  // A restart edge wins over a coincident overflow or mid-bit event.
  assign restart_edge = pnRestart & ~restart_q;
  assign step_en      = ovf & ~restart_edge;
  assign mid_en       = mid & ~restart_edge;

  assign len = clamp_len(pnPolyLength);

  // Seed doubles as the active-stage mask: all ones in the low L bits.
  always_comb begin
    seed = '0;
    for (int k = 0; k < PN_WIDTH; k++) seed[k] = (k < int'(len));
  end

  always_comb begin
    step_out = sr[len - 5'd1];
    fib_fb   = ^(sr & pnPolyTaps & seed);
    if (pnPolyMode == PN_GALOIS)
      sr_step = ((sr << 1) ^ (step_out ? pnPolyTaps : '0)) & seed;
    else
      sr_step = ((sr << 1) | {{(PN_WIDTH-1){1'b0}}, fib_fb}) & seed;
    // All-zero is a lockup state for any tap set; reload the seed in place.
    sr_next = (sr_step == '0) ? seed : sr_step;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      acc       <= '0;
      sr        <= seed;
      restart_q <= 1'b0;
      pnBit     <= 1'b0;
      pnClk     <= 1'b0;
      pnBitEn   <= 1'b0;
    end else begin
      restart_q <= pnRestart;
      pnClk     <= nco_sum[RATE_WIDTH-1];
      pnBitEn   <= step_en;
      if (restart_edge) begin
        acc <= '0;
        sr  <= seed;
      end else begin
        acc <= nco_sum[RATE_WIDTH-1:0];
        if (step_en) begin
          sr    <= sr_next;
          pnBit <= step_out;
        end
      end
    end
  end

  // At a boundary the encoder sees the bit about to be output; at mid-bit
  // it sees the bit currently on pnBit.
  assign enc_bit = step_en ? step_out : pnBit;

  pcm_encoder u_encoder (
    .clk       (clk),
    .reset     (reset),
    .dataBit   (enc_bit),
    .bitEn     (step_en),
    .midEn     (mid_en),
    .pcmMode   (pcmMode),
    .pcmInvert (pcmInvert),
    .restart   (restart_edge),
    .data      (pnData)
  );

`ifdef PNGEN_EPOCH_EN
  // Set by reset/restart so the first step from a fresh seed is flagged too.
  logic epoch_pending;

  always_ff @(posedge clk) begin
    if (reset || restart_edge) begin
      pnEpoch       <= 1'b0;
      epoch_pending <= 1'b1;
    end else if (step_en) begin
      pnEpoch       <= epoch_pending | (sr_next == seed);
      epoch_pending <= 1'b0;
    end else begin
      pnEpoch       <= 1'b0;
    end
  end
`else
  assign pnEpoch = 1'b0;
`endif

endmodule

// File: tb/tb_pn_generator.sv
// tb_pn_generator -- self-checking bench for pn_generator.
// A behavioural model (per-stage bit array, integer NCO, half-bit line-code
// rules) predicts every output each cycle; sequence-level properties
// (period, ones count, lockup pattern, restart behaviour) are also checked.
module tb_pn_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] pnPolyTaps;
  logic [4:0]  pnPolyLength;
  logic        pnPolyMode;
  logic [31:0] pnClockRate;
  logic [3:0]  pcmMode;
  logic        pcmInvert;
  logic        pnRestart;
  logic        pnBit, pnData, pnClk, pnBitEn, pnEpoch;

  always #5 clk = ~clk;

  pn_generator dut (
    .clk          (clk),
    .reset        (reset),
    .pnPolyTaps   (pnPolyTaps),
    .pnPolyLength (pnPolyLength),
    .pnPolyMode   (pnPolyMode),
    .pnClockRate  (pnClockRate),
    .pcmMode      (pcmMode),
    .pcmInvert    (pcmInvert),
    .pnRestart    (pnRestart),
    .pnBit        (pnBit),
    .pnData       (pnData),
    .pnClk        (pnClk),
    .pnBitEn      (pnBitEn),
    .pnEpoch      (pnEpoch)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  localparam longint unsigned TWO32 = 64'h1_0000_0000;
  localparam longint unsigned HALF  = 64'h0_8000_0000;

  // ---------------- reference model ----------------
  longint unsigned m_acc;
  bit m_s[24];            // m_s[k] = stage k+1
  bit m_bit, m_clk, m_en, m_ep, m_lvl, m_rq, m_pend;

  bit bits_q[$];          // DUT bits observed at each pnBitEn

  function automatic int stages();
    int l = int'(pnPolyLength);
    if (l < 2)  l = 2;
    if (l > 24) l = 24;
    return l;
  endfunction

  function automatic bit seed_loaded(int l);
    for (int k = 0; k < 24; k++) if (m_s[k] != (k < l)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load_seed(int l);
    for (int k = 0; k < 24; k++) m_s[k] = (k < l);
  endtask

  task automatic lfsr_advance(int l, bit out);
    bit nxt[24];
    bit fb = 1'b0;
    bit any = 1'b0;
    for (int k = 0; k < 24; k++) nxt[k] = 1'b0;
    if (pnPolyMode) begin
      nxt[0] = out & pnPolyTaps[0];
      for (int k = 1; k < l; k++) nxt[k] = m_s[k-1] ^ (out & pnPolyTaps[k]);
    end else begin
      for (int k = 0; k < l; k++) fb ^= m_s[k] & pnPolyTaps[k];
      nxt[0] = fb;
      for (int k = 1; k < l; k++) nxt[k] = m_s[k-1];
    end
    for (int k = 0; k < l; k++) any |= nxt[k];
    if (!any) for (int k = 0; k < l; k++) nxt[k] = 1'b1;
    m_s = nxt;
  endtask

  function automatic int code();
    return (pcmMode > 4'd6) ? 0 : int'(pcmMode);
  endfunction

  task automatic model_edge();
    int l = stages();
    longint unsigned sum;
    bit ovf, mid, rise, out;
    if (reset) begin
      m_acc = 0; load_seed(l);
      m_bit = 0; m_clk = 0; m_en = 0; m_ep = 0; m_lvl = 0; m_rq = 0; m_pend = 1;
      return;
    end
    rise = pnRestart && !m_rq;
    m_rq = pnRestart;
    sum  = m_acc + longint'(pnClockRate);
    ovf  = sum >= TWO32;
    sum  = sum % TWO32;
    mid  = !ovf && (m_acc < HALF) && (sum >= HALF);
    m_clk = sum >= HALF;
    m_en = 0;
    m_ep = 0;
    if (rise) begin
      m_acc = 0; load_seed(l); m_lvl = 0; m_pend = 1;
    end else begin
      m_acc = sum;
      if (ovf) begin
        out = m_s[l-1];
        lfsr_advance(l, out);
        m_bit = out;
        m_en  = 1;
        m_ep  = m_pend || seed_loaded(l);
        m_pend = 0;
        case (code())
          1:       if (out)  m_lvl = !m_lvl;
          2:       if (!out) m_lvl = !m_lvl;
          4, 5:    m_lvl = !m_lvl;
          default: m_lvl = out;
        endcase
      end else if (mid) begin
        case (code())
          3:       m_lvl = !m_bit;
          4:       if (m_bit)  m_lvl = !m_lvl;
          5:       if (!m_bit) m_lvl = !m_lvl;
          6:       m_lvl = 0;
          default: ;
        endcase
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic exp_ep;
    @(posedge clk);
    model_edge();
    #1;
`ifdef PNGEN_EPOCH_EN
    exp_ep = m_ep;
`else
    exp_ep = 1'b0;
`endif
    chk("pnBit",   pnBit,   m_bit);
    chk("pnData",  pnData,  m_lvl ^ pcmInvert);
    chk("pnClk",   pnClk,   m_clk);
    chk("pnBitEn", pnBitEn, m_en);
    chk("pnEpoch", pnEpoch, exp_ep);
    if (pnBitEn === 1'b1) bits_q.push_back(pnBit);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic collect(input int nbits, input int budget);
    bits_q.delete();
    for (int i = 0; i < budget && bits_q.size() < nbits; i++) tick();
    chk_int("bit_collect_timeout", (bits_q.size() >= nbits) ? 1 : 0, 1);
  endtask

  task automatic restart_pulse();
    pnRestart = 1'b1; tick();
    pnRestart = 1'b0; tick();
  endtask

  function automatic int ones(input int first, input int n);
    int c = 0;
    for (int i = first; i < first + n && i < bits_q.size(); i++) c += bits_q[i];
    return c;
  endfunction

  function automatic int period_errs(input int p);
    int e = 0;
    for (int i = 0; i + p < bits_q.size(); i++) if (bits_q[i] != bits_q[i+p]) e++;
    return e;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic held_data, held_bit, held_clk;

    reset        = 1'b1;
    pnPolyTaps   = 24'h000110;
    pnPolyLength = 5'd9;
    pnPolyMode   = 1'b0;
    pnClockRate  = 32'h4000_0000;
    pcmMode      = 4'd0;
    pcmInvert    = 1'b0;
    pnRestart    = 1'b0;
    run(3);
    chk("reset_pnBitEn", pnBitEn, 1'b0);
    chk("reset_pnData",  pnData,  1'b0);
    reset = 1'b0;

    // PN9 Fibonacci, NRZ-L, 4 clk/bit: period 511, 256 ones.
    collect(1022, 4300);
    chk_int("pn9_ones", ones(0, 511), 256);
    chk_int("pn9_period", period_errs(511), 0);
    chk_int("pn9_first_bit", int'(bits_q[0]), 1);

    // PN7 Galois, 8 clk/bit: period 127, 64 ones.
    pnPolyTaps = 24'h000041; pnPolyLength = 5'd7; pnPolyMode = 1'b1;
    pnClockRate = 32'h2000_0000;
    restart_pulse();
    collect(254, 2200);
    chk_int("pn7_ones", ones(0, 127), 64);
    chk_int("pn7_period", period_errs(127), 0);

    // NRZ-M on PN9, invert flipped mid-run.
    pnPolyTaps = 24'h000110; pnPolyLength = 5'd9; pnPolyMode = 1'b0;
    pnClockRate = 32'h4000_0000; pcmMode = 4'd1;
    restart_pulse();
    run(40);
    pnClockRate = 32'h0;
    tick();
    held_data = pnData;
    pcmInvert = 1'b1;
    tick();
    chk("invert_next_cycle", pnData, ~held_data);
    pnClockRate = 32'h4000_0000;
    run(40);
    pcmInvert = 1'b0;

    // Biphase-L at 8 clk/bit, then an unused code behaving as NRZ-L.
    pcmMode = 4'd3; pnClockRate = 32'h2000_0000;
    run(64);
    pcmMode = 4'd9;
    run(64);

    // Lockup: no taps, L=4 -> bits 1,1,1,1 repeating.
    pnPolyTaps = 24'h0; pnPolyLength = 5'd4; pnPolyMode = 1'b0;
    pnClockRate = 32'h4000_0000; pcmMode = 4'd0;
    restart_pulse();
    collect(12, 100);
    chk_int("lockup_ones", ones(0, 12), 12);

    // Restart edge coincident with an overflow.
    pnPolyTaps = 24'h000110; pnPolyLength = 5'd9;
    for (int i = 0; i < 8 && (m_acc + longint'(pnClockRate)) < TWO32; i++) tick();
    pnRestart = 1'b1;
    tick();
    chk("restart_no_bitEn", pnBitEn, 1'b0);
    collect(1, 8);
    chk_int("restart_first_bit", int'(bits_q[0]), 1);
    run(10);   // restart held high: no further effect

    // rate = 0 holds everything.
    pnClockRate = 32'h0;
    tick();
    held_data = pnData; held_bit = pnBit; held_clk = pnClk;
    run(16);
    chk("hold_pnData", pnData, held_data);
    chk("hold_pnBit",  pnBit,  held_bit);
    chk("hold_pnClk",  pnClk,  held_clk);
    pnRestart = 1'b0;

    // Randomised configurations, changed on the fly without reseeding.
    for (int r = 0; r < 8; r++) begin
      pnPolyTaps   = 24'($urandom);
      pnPolyLength = 5'($urandom_range(0, 31));
      pnPolyMode   = 1'($urandom_range(0, 1));
      pcmMode      = 4'($urandom_range(0, 15));
      pcmInvert    = 1'($urandom_range(0, 1));
      pnClockRate  = $urandom_range(32'h0800_0000, 32'h7FFF_FFFF);
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 49) == 0) pnRestart = ~pnRestart;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
